// File: rtl/button_event_gen.sv
// Turns a debounced button level into press / auto-repeat / release pulses and a held level.
// Outputs are registered, 1 cycle after the sampled level; there is no backpressure, and enable_in low locks events out.
module button_event_gen #(
   parameter logic [31:0] HOLD_CYCLES   = 32'd50_000_000,
   parameter logic [31:0] REPEAT_CYCLES = 32'd10_000_000
) (
   input  logic clk_in,
   input  logic reset_in,
   input  logic button_in,
   input  logic enable_in,
   output logic press_out,
   output logic repeat_out,
   output logic release_out,
   output logic held_out
);

   typedef enum logic [1:0] {
      ST_BLOCKED = 2'd0,
      ST_IDLE    = 2'd1,
      ST_WAIT    = 2'd2,
      ST_REPEAT  = 2'd3
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] cnt, cnt_nxt;
   logic        press_nxt, repeat_nxt, release_nxt, held_nxt;

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state       <= ST_BLOCKED;
         cnt         <= 32'd0;
         press_out   <= 1'b0;
         repeat_out  <= 1'b0;
         release_out <= 1'b0;
         held_out    <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         press_out   <= press_nxt;
         repeat_out  <= repeat_nxt;
         release_out <= release_nxt;
         held_out    <= held_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      press_nxt   = 1'b0;
      repeat_nxt  = 1'b0;
      release_nxt = 1'b0;
      held_nxt    = held_out;

      if (!enable_in) begin
         // Lockout: a button still down when re-enabled must first be seen low.
         state_nxt = ST_BLOCKED;
         cnt_nxt   = 32'd0;
         held_nxt  = 1'b0;
      end else begin
         case (state)
            ST_BLOCKED: begin
               if (!button_in) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
               if (button_in) begin
                  state_nxt = ST_WAIT;
                  cnt_nxt   = 32'd1;
                  press_nxt = 1'b1;
               end
            end
            ST_WAIT: begin
               if (!button_in) begin
                  state_nxt   = ST_IDLE;
                  cnt_nxt     = 32'd0;
                  release_nxt = 1'b1;
                  held_nxt    = 1'b0;
               end else if (cnt == HOLD_CYCLES) begin
                  state_nxt  = ST_REPEAT;
                  cnt_nxt    = 32'd1;
                  repeat_nxt = 1'b1;
                  held_nxt   = 1'b1;
               end else begin
                  cnt_nxt = cnt + 32'd1;
               end
            end
            ST_REPEAT: begin
               // Release takes priority over a coincident repeat tick.
               if (!button_in) begin
                  state_nxt   = ST_IDLE;
                  cnt_nxt     = 32'd0;
                  release_nxt = 1'b1;
                  held_nxt    = 1'b0;
               end else if (cnt == REPEAT_CYCLES) begin
                  cnt_nxt    = 32'd1;
                  repeat_nxt = 1'b1;
               end else begin
                  cnt_nxt = cnt + 32'd1;
               end
            end
            default: begin
               state_nxt = ST_BLOCKED;
               cnt_nxt   = 32'd0;
               held_nxt  = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_button_event_gen.sv
// Bench for button_event_gen: two instances (4/3 and 1/1) on shared stimulus against a hold-duration model.
module tb_button_event_gen;

   logic       clk_in = 1'b0;
   logic       reset_in;
   logic       button_in;
   logic       enable_in;
   logic [1:0] press_o, repeat_o, release_o, held_o;

   int checks = 0;
   int errors = 0;

   // Model: armed = button seen low since reset/enable, dur = cycles held since press.
   int   hold_p[2] = '{4, 1};
   int   rep_p[2]  = '{3, 1};
   bit   armed[2];
   bit   pressed[2];
   int   dur[2];
   logic e_press[2], e_rep[2], e_rel[2], e_held[2];

   button_event_gen #(.HOLD_CYCLES(32'd4), .REPEAT_CYCLES(32'd3)) dut0 (
      .clk_in(clk_in), .reset_in(reset_in), .button_in(button_in), .enable_in(enable_in),
      .press_out(press_o[0]), .repeat_out(repeat_o[0]), .release_out(release_o[0]), .held_out(held_o[0])
   );

   button_event_gen #(.HOLD_CYCLES(32'd1), .REPEAT_CYCLES(32'd1)) dut1 (
      .clk_in(clk_in), .reset_in(reset_in), .button_in(button_in), .enable_in(enable_in),
      .press_out(press_o[1]), .repeat_out(repeat_o[1]), .release_out(release_o[1]), .held_out(held_o[1])
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         armed[i] = 0; pressed[i] = 0; dur[i] = 0;
         e_press[i] = 0; e_rep[i] = 0; e_rel[i] = 0; e_held[i] = 0;
      end
   endtask

   task automatic model_tick(input int i, input logic b, input logic en);
      e_press[i] = 0; e_rep[i] = 0; e_rel[i] = 0;
      if (!en) begin
         armed[i] = 0; pressed[i] = 0; e_held[i] = 0;
      end else if (pressed[i]) begin
         if (!b) begin
            pressed[i] = 0; e_rel[i] = 1; e_held[i] = 0;
         end else begin
            dur[i]++;
            e_held[i] = (dur[i] >= hold_p[i]);
            e_rep[i]  = (dur[i] >= hold_p[i]) && ((dur[i] - hold_p[i]) % rep_p[i] == 0);
         end
      end else if (!armed[i]) begin
         if (!b) armed[i] = 1;
      end else if (b) begin
         pressed[i] = 1; dur[i] = 0; e_press[i] = 1;
      end
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("%s.u%0d.press", tag, i), 32'(press_o[i]), 32'(e_press[i]));
         chk($sformatf("%s.u%0d.repeat", tag, i), 32'(repeat_o[i]), 32'(e_rep[i]));
         chk($sformatf("%s.u%0d.release", tag, i), 32'(release_o[i]), 32'(e_rel[i]));
         chk($sformatf("%s.u%0d.held", tag, i), 32'(held_o[i]), 32'(e_held[i]));
         chk($sformatf("%s.u%0d.onehot", tag, i),
             32'($countones({press_o[i], repeat_o[i], release_o[i]}) <= 1), 32'd1);
      end
   endtask

   // Drive inputs, clock one edge, advance the model, check 1 ns after the edge.
   task automatic cyc(input string tag, input logic b, input logic en);
      button_in = b;
      enable_in = en;
      @(posedge clk_in);
      for (int i = 0; i < 2; i++) model_tick(i, b, en);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset(input string tag, input logic b);
      button_in = b;
      enable_in = 1'b1;
      reset_in  = 1'b1;
      model_reset();
      #1;
      check_all({tag, ".async"});
      repeat (2) @(posedge clk_in);
      #1;
      check_all({tag, ".held"});
      reset_in = 1'b0;
   endtask

   initial begin
      int  nrep;
      int  first_held;
      logic b;
      logic en;

      reset_in  = 1'b1;
      button_in = 1'b0;
      enable_in = 1'b1;
      model_reset();
      @(posedge clk_in);
      #1;
      do_reset("rst0", 1'b0);

      // Short tap: press, release two cycles later, no repeat for the 4/3 instance.
      cyc("arm", 1'b0, 1'b1);
      cyc("tap", 1'b1, 1'b1);
      cyc("tap", 1'b1, 1'b1);
      cyc("tap_rel", 1'b0, 1'b1);
      cyc("idle", 1'b0, 1'b1);

      // Hold 14 cycles: repeats at +4, +7, +10, +13 relative to the press.
      nrep = 0;
      first_held = -1;
      for (int k = 0; k < 14; k++) begin
         cyc("hold14", 1'b1, 1'b1);
         if (repeat_o[0]) nrep++;
         if (held_o[0] && first_held < 0) first_held = k;
      end
      chk("hold14.rep_count", 32'(nrep), 32'd4);
      chk("hold14.first_held", 32'(first_held), 32'd4);
      cyc("hold14_rel", 1'b0, 1'b1);
      cyc("idle", 1'b0, 1'b1);

      // Button down across reset: locked out until seen low.
      do_reset("rst_held", 1'b1);
      for (int k = 0; k < 4; k++) cyc("locked", 1'b1, 1'b1);
      cyc("unlock", 1'b0, 1'b1);
      cyc("repress", 1'b1, 1'b1);

      // Enable dropped while repeating: held clears, no release, relock.
      for (int k = 0; k < 6; k++) cyc("to_repeat", 1'b1, 1'b1);
      cyc("en_drop", 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) cyc("en_back", 1'b1, 1'b1);
      cyc("en_low", 1'b0, 1'b1);
      cyc("en_press", 1'b1, 1'b1);

      // Release lands on the edge where the repeat counter matches.
      cyc("gap", 1'b0, 1'b1);
      cyc("coin_press", 1'b1, 1'b1);
      for (int k = 0; k < 6; k++) cyc("coin_hold", 1'b1, 1'b1);
      cyc("coin_rel", 1'b0, 1'b1);
      chk("coin_rel.rep_suppressed", 32'(repeat_o[0]), 32'd0);

      // Asynchronous reset pulled mid-WAIT, between clock edges.
      cyc("mid_press", 1'b1, 1'b1);
      cyc("mid_wait", 1'b1, 1'b1);
      #3;
      do_reset("rst_mid", 1'b1);
      cyc("post_rst", 1'b1, 1'b1);
      cyc("post_rst_low", 1'b0, 1'b1);

      // Random runs of button and occasional enable drops.
      b = 1'b0;
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(7) == 0) b = ~b;
         en = ($urandom_range(39) != 0);
         cyc("rand", b, en);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
